// File: rtl/hazard_ctrl.sv
// Stall, E-flush and forwarding control for a 5-stage MIPS pipeline, with M/W shadow registers.
// Define MULDIV_EN to add a mult/div busy counter that stalls HI/LO readers in D.
module hazard_ctrl
`ifdef MULDIV_EN
#(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ra1D,
    input  logic [4:0] ra2D,
    input  logic [1:0] tuse1D,
    input  logic [1:0] tuse2D,
    input  logic [4:0] ra1E,
    input  logic [4:0] ra2E,
    input  logic [4:0] waE,
    input  logic [1:0] resE,
`ifdef MULDIV_EN
    input  logic       mdstartE,
    input  logic       mdopE,
    input  logic       mduseD,
    output logic       busy,
`endif
    output logic       stall,
    output logic       Eclr,
    output logic [1:0] fwd1D,
    output logic [1:0] fwd2D,
    output logic [1:0] fwd1E,
    output logic [1:0] fwd2E,
    output logic       fwd2M,
    output logic [4:0] waM,
    output logic [4:0] waW,
    output logic [1:0] resM,
    output logic [1:0] resW
);

    localparam logic [1:0] RES_NW  = 2'd0;
    localparam logic [1:0] RES_ALU = 2'd1;
    localparam logic [1:0] RES_DM  = 2'd2;

    logic [4:0] wa_m_q, wa_m_d, ra2_m_q, ra2_m_d, wa_w_q, wa_w_d;
    logic [1:0] res_m_q, res_m_d, res_w_q, res_w_d;
    logic [1:0] tnew_e, tnew_m;
    logic       md_stall;

    function automatic logic hit(input logic [4:0] src, input logic [4:0] wa, input logic [1:0] res);
        return (src != 5'd0) && (src == wa) && (res != RES_NW);
    endfunction

    // The youngest hitting stage owns the register, so an E hit masks M entirely.
    function automatic logic src_stall(input logic [1:0] tuse, input logic he, input logic hm,
                                       input logic [1:0] te, input logic [1:0] tm);
        logic s;
        s = 1'b0;
        if (tuse != 2'd3) begin
            if (he)      s = (tuse < te);
            else if (hm) s = (tuse < tm);
        end
        return s;
    endfunction

    function automatic logic [1:0] sel_d(input logic he, input logic hm, input logic hw,
                                         input logic [1:0] te, input logic [1:0] tm);
        logic [1:0] sel;
        sel = 2'd0;
        if (he) begin
            if (te == 2'd0) sel = 2'd1;
        end else if (hm) begin
            if (tm == 2'd0) sel = 2'd2;
        end else if (hw) begin
            sel = 2'd3;
        end
        return sel;
    endfunction

    function automatic logic [1:0] sel_e(input logic hm, input logic hw, input logic [1:0] tm);
        logic [1:0] sel;
        sel = 2'd0;
        if (hm && (tm == 2'd0)) sel = 2'd2;
        else if (hw)            sel = 2'd3;
        return sel;
    endfunction

    always_comb begin
        tnew_e = 2'd0;
        if (resE == RES_ALU)     tnew_e = 2'd1;
        else if (resE == RES_DM) tnew_e = 2'd2;
        tnew_m = (res_m_q == RES_DM) ? 2'd1 : 2'd0;
    end

    always_comb begin
        stall = md_stall
              | src_stall(tuse1D, hit(ra1D, waE, resE), hit(ra1D, wa_m_q, res_m_q), tnew_e, tnew_m)
              | src_stall(tuse2D, hit(ra2D, waE, resE), hit(ra2D, wa_m_q, res_m_q), tnew_e, tnew_m);
        Eclr  = stall;
        fwd1D = sel_d(hit(ra1D, waE, resE), hit(ra1D, wa_m_q, res_m_q), hit(ra1D, wa_w_q, res_w_q),
                      tnew_e, tnew_m);
        fwd2D = sel_d(hit(ra2D, waE, resE), hit(ra2D, wa_m_q, res_m_q), hit(ra2D, wa_w_q, res_w_q),
                      tnew_e, tnew_m);
        fwd1E = sel_e(hit(ra1E, wa_m_q, res_m_q), hit(ra1E, wa_w_q, res_w_q), tnew_m);
        fwd2E = sel_e(hit(ra2E, wa_m_q, res_m_q), hit(ra2E, wa_w_q, res_w_q), tnew_m);
        fwd2M = hit(ra2_m_q, wa_w_q, res_w_q);
    end

    always_comb begin
        wa_m_d  = waE;
        res_m_d = resE;
        ra2_m_d = ra2E;
        wa_w_d  = wa_m_q;
        res_w_d = res_m_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wa_m_q  <= '0;
            res_m_q <= '0;
            ra2_m_q <= '0;
            wa_w_q  <= '0;
            res_w_q <= '0;
        end else begin
            wa_m_q  <= wa_m_d;
            res_m_q <= res_m_d;
            ra2_m_q <= ra2_m_d;
            wa_w_q  <= wa_w_d;
            res_w_q <= res_w_d;
        end
    end

    assign waM  = wa_m_q;
    assign waW  = wa_w_q;
    assign resM = res_m_q;
    assign resW = res_w_q;

`ifdef MULDIV_EN
    localparam int CNT_W = $clog2(((MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC) + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load N-1 because the start cycle itself already reports busy: busy spans exactly N cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (mdstartE && (cnt_q == '0))
            cnt_d = mdopE ? CNT_W'(DIV_CYC - 1) : CNT_W'(MUL_CYC - 1);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign busy     = (cnt_q != '0) || mdstartE;
    assign md_stall = busy && mduseD;
`else
    assign md_stall = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] ra1D, ra2D, ra1E, ra2E, waE;
    logic [1:0] tuse1D, tuse2D, resE;
    logic       stall, Eclr, fwd2M, busy_s;
    logic [1:0] fwd1D, fwd2D, fwd1E, fwd2E, resM, resW;
    logic [4:0] waM, waW;

`ifdef MULDIV_EN
    logic mdstartE = 1'b0, mdopE = 1'b0, mduseD = 1'b0;
    logic nx_start = 1'b0, nx_op = 1'b0, nx_use = 1'b0;
`else
    assign busy_s = 1'b0;
`endif

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .ra1D(ra1D), .ra2D(ra2D), .tuse1D(tuse1D), .tuse2D(tuse2D),
        .ra1E(ra1E), .ra2E(ra2E), .waE(waE), .resE(resE),
`ifdef MULDIV_EN
        .mdstartE(mdstartE), .mdopE(mdopE), .mduseD(mduseD), .busy(busy_s),
`endif
        .stall(stall), .Eclr(Eclr),
        .fwd1D(fwd1D), .fwd2D(fwd2D), .fwd1E(fwd1E), .fwd2E(fwd2E), .fwd2M(fwd2M),
        .waM(waM), .waW(waW), .resM(resM), .resW(resW)
    );

    logic [25:0] obs;
    assign obs = {busy_s, stall, Eclr, fwd1D, fwd2D, fwd1E, fwd2E, fwd2M, waM, waW, resM, resW};

    logic [25:0] exp_q[$];
    int          id_q[$];
    int          vec_n = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    // Field order of the packed value: busy stall Eclr f1D f2D f1E f2E f2M waM waW resM resW
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [25:0] e;
            int          id;
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            total_cnt++;
            if (obs === e) pass_cnt++;
            else $display("FAIL vec%0d outputs got=%h exp=%h", id, obs, e);
        end
    end

    task automatic step(input logic r,
                        input logic [4:0] a1d, input logic [4:0] a2d,
                        input logic [1:0] t1, input logic [1:0] t2,
                        input logic [4:0] a1e, input logic [4:0] a2e,
                        input logic [4:0] we, input logic [1:0] re,
                        input logic e_st,
                        input logic [1:0] e1d, input logic [1:0] e2d,
                        input logic [1:0] e1e, input logic [1:0] e2e, input logic e2m,
                        input logic [4:0] ewm, input logic [4:0] eww,
                        input logic [1:0] erm, input logic [1:0] erw,
                        input logic e_busy = 1'b0);
        @(posedge clk);
        #1;
        rst = r; ra1D = a1d; ra2D = a2d; tuse1D = t1; tuse2D = t2;
        ra1E = a1e; ra2E = a2e; waE = we; resE = re;
`ifdef MULDIV_EN
        mdstartE = nx_start; mdopE = nx_op; mduseD = nx_use;
`endif
        exp_q.push_back({e_busy, e_st, e_st, e1d, e2d, e1e, e2e, e2m, ewm, eww, erm, erw});
        id_q.push_back(vec_n);
        vec_n++;
    endtask

    task automatic idle(input logic e_st, input logic e_busy, input logic r = 1'b0);
        step(r, 0,0,3,3, 0,0,0,0, e_st, 0,0,0,0,0, 0,0,0,0, e_busy);
    endtask

    initial begin
        rst = 1'b1; ra1D = '0; ra2D = '0; tuse1D = 2'd3; tuse2D = 2'd3;
        ra1E = '0; ra2E = '0; waE = '0; resE = '0;
        repeat (2) @(posedge clk);

        //    r  a1d a2d t1 t2  a1e a2e we re  st f1D f2D f1E f2E f2M waM waW resM resW
        step(0,  0,  0, 3, 3,  0,  0, 0, 0,  0, 0,  0,  0,  0,  0,  0,  0,  0,  0);
        step(0,  8,  0, 1, 3,  0,  0, 8, 2,  1, 0,  0,  0,  0,  0,  0,  0,  0,  0);
        step(0,  8,  0, 1, 3,  0,  0, 0, 0,  0, 0,  0,  0,  0,  0,  8,  0,  2,  0);
        step(0,  0,  0, 3, 3,  8,  0,10, 1,  0, 0,  0,  3,  0,  0,  0,  8,  0,  2);
        step(0,  9,  0, 0, 3,  0,  0, 9, 1,  1, 0,  0,  0,  0,  0, 10,  0,  1,  0);
        step(0,  9, 10, 0, 0,  0,  0, 0, 0,  0, 2,  3,  0,  0,  0,  9, 10,  1,  1);
        step(0, 31,  0, 0, 3,  0,  0,31, 3,  0, 1,  0,  0,  0,  0,  0,  9,  0,  1);
        step(0,  0,  0, 3, 3, 31,  0, 5, 1,  0, 0,  0,  2,  0,  0, 31,  0,  3,  0);
        step(0,  0,  0, 0, 3,  5, 31, 5, 1,  0, 0,  0,  2,  3,  0,  5, 31,  1,  3);
        step(0,  0,  5, 0, 0,  5,  0, 0, 1,  0, 0,  2,  2,  0,  0,  5,  5,  1,  1);
        step(0,  4,  4, 3, 2,  0,  0, 4, 2,  0, 0,  0,  0,  0,  0,  0,  5,  1,  1);
        step(0,  0,  0, 3, 3,  0,  4, 0, 0,  0, 0,  0,  0,  0,  0,  4,  0,  2,  1);
        step(0,  0,  0, 3, 3,  0,  0, 0, 0,  0, 0,  0,  0,  0,  1,  0,  4,  0,  2);
        step(0,  7,  0, 0, 3,  0,  0, 7, 0,  0, 0,  0,  0,  0,  0,  0,  0,  0,  0);
        step(0,  7,  0, 0, 3,  0,  0,12, 1,  0, 0,  0,  0,  0,  0,  7,  0,  0,  0);
        step(1, 12,  0, 0, 3,  0,  0,13, 2,  0, 2,  0,  0,  0,  0, 12,  7,  1,  0);
        step(0,  0,  0, 3, 3,  0,  0, 0, 0,  0, 0,  0,  0,  0,  0,  0,  0,  0,  0);
        step(0,  0,  0, 3, 3,  0,  0, 3, 1,  0, 0,  0,  0,  0,  0,  0,  0,  0,  0);
        step(0,  0,  0, 3, 3,  0,  0, 0, 0,  0, 0,  0,  0,  0,  0,  3,  0,  1,  0);
        step(0,  0,  6, 3, 0,  0,  0, 6, 2,  1, 0,  0,  0,  0,  0,  0,  3,  0,  1);
        step(0,  0,  0, 3, 3,  0,  0, 0, 0,  0, 0,  0,  0,  0,  0,  6,  0,  2,  0);
        step(0,  0,  0, 3, 3,  0,  0, 0, 0,  0, 0,  0,  0,  0,  0,  0,  6,  0,  2);
        step(0,  0,  0, 3, 3,  0,  0,11, 2,  0, 0,  0,  0,  0,  0,  0,  0,  0,  0);
        step(0, 11,  0, 0, 3,  0,  0,11, 3,  0, 1,  0,  0,  0,  0, 11,  0,  2,  0);
        step(0,  0,  0, 3, 3,  0,  0, 0, 0,  0, 0,  0,  0,  0,  0, 11, 11,  3,  2);
        step(0,  0,  0, 3, 3,  0,  0, 0, 0,  0, 0,  0,  0,  0,  0,  0, 11,  0,  3);
        idle(0, 0);

`ifdef MULDIV_EN
        // div: busy for 10 cycles counting the start cycle
        nx_use = 1'b1; nx_op = 1'b1; nx_start = 1'b1;
        idle(1, 1);
        nx_start = 1'b0;
        for (int i = 1; i < 10; i++) idle(1, 1);
        idle(0, 0);
        // mult, with a second start while busy that must be ignored
        nx_op = 1'b0; nx_start = 1'b1;
        idle(1, 1);
        nx_op = 1'b1;
        idle(1, 1);
        nx_start = 1'b0;
        for (int i = 0; i < 3; i++) idle(1, 1);
        idle(0, 0);
        // reset in the middle of a divide
        nx_start = 1'b1;
        idle(1, 1);
        nx_start = 1'b0;
        idle(1, 1);
        idle(1, 1);
        idle(1, 1, 1'b1);
        idle(0, 0);
        nx_use = 1'b0;
        idle(0, 0);
`endif

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain monitor left=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
